// File: rtl/quiz_round_controller.sv
// rtl/quiz_round_controller.sv - quiz round sequencer, round-robin buzzer arbiter and score keeper
module quiz_round_controller #(
  parameter int NUM_PLAYERS   = 4,
  parameter int CLOCK_FREQ    = 50000000,
  parameter int ANSWER_TIME_S = 10,
  parameter int RESULT_TIME_S = 3,
  parameter int SCORE_WIDTH   = 4,
  localparam int IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                               clock,
  input  logic                               globalReset,
  input  logic                               startRound,
  input  logic [NUM_PLAYERS-1:0]             buzz,
  input  logic                               judgeValid,
  input  logic                               judgeCorrect,
  output logic [1:0]                         screenSel,
  output logic                               roundActive,
  output logic                               winnerValid,
  output logic [IW-1:0]                      winnerId,
  output logic [7:0]                         secondsLeft,
  output logic [NUM_PLAYERS-1:0]             lockout,
  output logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores
);

  localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_ANSWER, S_RESULT} state_t;

  state_t                 r_state;
  logic [PW-1:0]          r_presc;
  logic [IW-1:0]          r_ptr;
  logic [NUM_PLAYERS-1:0] r_buzz_prev;
  logic                   r_verdict;
  logic [SCORE_WIDTH-1:0] r_scores [NUM_PLAYERS];

  logic                   w_tick;
  logic                   w_last_sec;
  logic                   w_judge_ok;
  logic                   w_any_press;
  logic [IW-1:0]          w_winner;
  logic [NUM_PLAYERS-1:0] w_press;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PLAYERS) sum = sum - NUM_PLAYERS;
    return IW'(sum);
  endfunction

  assign w_tick     = (r_presc == PW'(CLOCK_FREQ - 1));
  assign w_last_sec = w_tick && (secondsLeft == 8'd1);
  assign w_judge_ok = judgeValid && judgeCorrect;
  assign w_press    = buzz & ~r_buzz_prev & ~lockout;

  // First set press at or above the pointer, wrapping around, wins.
  always_comb begin
    w_any_press = 1'b0;
    w_winner    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!w_any_press && w_press[rr_idx(r_ptr, i)]) begin
        w_any_press = 1'b1;
        w_winner    = rr_idx(r_ptr, i);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PLAYERS; g++) begin : g_pack
      assign scores[g*SCORE_WIDTH +: SCORE_WIDTH] = r_scores[g];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (globalReset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_ptr       <= '0;
      r_buzz_prev <= '0;
      r_verdict   <= 1'b0;
      screenSel   <= 2'b01;
      roundActive <= 1'b0;
      winnerValid <= 1'b0;
      winnerId    <= '0;
      secondsLeft <= 8'd0;
      lockout     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
    end else begin
      r_buzz_prev <= buzz;
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (startRound) begin
            lockout     <= '0;
            secondsLeft <= 8'(ANSWER_TIME_S);
            roundActive <= 1'b1;
            r_state     <= S_OPEN;
          end
        end
        S_OPEN: begin
          if (w_any_press) begin
            winnerId    <= w_winner;
            r_ptr       <= rr_idx(w_winner, 1);
            secondsLeft <= 8'(ANSWER_TIME_S);
            winnerValid <= 1'b1;
            r_presc     <= '0;
            r_state     <= S_ANSWER;
          end else if (w_tick) begin
            r_presc     <= '0;
            secondsLeft <= secondsLeft - 8'd1;
            if (w_last_sec) begin
              roundActive <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        S_ANSWER: begin
          // A judge strobe in the final second overrides the timeout.
          if (judgeValid || w_last_sec) begin
            r_verdict <= w_judge_ok;
            if (w_judge_ok) begin
              screenSel <= 2'b11;
              if (r_scores[winnerId] != '1)
                r_scores[winnerId] <= r_scores[winnerId] + 1'b1;
            end else begin
              screenSel         <= 2'b10;
              lockout[winnerId] <= 1'b1;
            end
            secondsLeft <= 8'(RESULT_TIME_S);
            r_presc     <= '0;
            r_state     <= S_RESULT;
          end else if (w_tick) begin
            r_presc     <= '0;
            secondsLeft <= secondsLeft - 8'd1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        S_RESULT: begin
          if (w_tick) begin
            r_presc <= '0;
            if (w_last_sec) begin
              screenSel   <= 2'b01;
              winnerValid <= 1'b0;
              if (r_verdict || (&lockout)) begin
                secondsLeft <= 8'd0;
                roundActive <= 1'b0;
                r_state     <= S_IDLE;
              end else begin
                secondsLeft <= 8'(ANSWER_TIME_S);
                r_state     <= S_OPEN;
              end
            end else begin
              secondsLeft <= secondsLeft - 8'd1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_controller.sv
// tb/tb_quiz_round_controller.sv - directed vector bench for quiz_round_controller
module tb_quiz_round_controller;

  logic        clock = 1'b0;
  logic        globalReset = 1'b1;
  logic        startRound = 1'b0;
  logic [3:0]  buzz = 4'b0000;
  logic        judgeValid = 1'b0;
  logic        judgeCorrect = 1'b0;
  logic [1:0]  screenSel;
  logic        roundActive;
  logic        winnerValid;
  logic [1:0]  winnerId;
  logic [7:0]  secondsLeft;
  logic [3:0]  lockout;
  logic [15:0] scores;

  int errors = 0;
  int checks = 0;

  quiz_round_controller #(
    .NUM_PLAYERS(4), .CLOCK_FREQ(10), .ANSWER_TIME_S(5), .RESULT_TIME_S(2), .SCORE_WIDTH(4)
  ) dut (
    .clock(clock), .globalReset(globalReset), .startRound(startRound), .buzz(buzz),
    .judgeValid(judgeValid), .judgeCorrect(judgeCorrect), .screenSel(screenSel),
    .roundActive(roundActive), .winnerValid(winnerValid), .winnerId(winnerId),
    .secondsLeft(secondsLeft), .lockout(lockout), .scores(scores)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  bz;
    logic        jv;
    logic        jc;
    int          cycles;
    logic [1:0]  scr;
    logic        act;
    logic        wv;
    logic [1:0]  wid;
    logic [7:0]  sl;
    logic [3:0]  lock;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic start, input logic [3:0] bz, input logic jv,
                     input logic jc, input int cycles, input logic [1:0] scr, input logic act,
                     input logic wv, input logic [1:0] wid, input logic [7:0] sl,
                     input logic [3:0] lock, input logic [15:0] sc);
    vec_t v;
    v.rst = rst; v.start = start; v.bz = bz; v.jv = jv; v.jc = jc; v.cycles = cycles;
    v.scr = scr; v.act = act; v.wv = wv; v.wid = wid; v.sl = sl; v.lock = lock; v.sc = sc;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [33:0] want);
    logic [33:0] got;
    got = {screenSel, roundActive, winnerValid, winnerId, secondsLeft, lockout, scores};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got scr=%b act=%b wv=%b wid=%0d sl=%0d lock=%b sc=%h, want scr=%b act=%b wv=%b wid=%0d sl=%0d lock=%b sc=%h",
               name, got[33:32], got[31], got[30], got[29:28], got[27:20], got[19:16], got[15:0],
               want[33:32], want[31], want[30], want[29:28], want[27:20], want[19:16], want[15:0]);
    end
  endtask

  initial begin
    // rst start buzz jv jc cyc | scr act wv wid sl lock scores
    add(0,1,4'b0000,0,0, 1, 2'b01,1,0,0,5,4'b0000,16'h0000);
    add(0,0,4'b0100,0,0, 1, 2'b01,1,1,2,5,4'b0000,16'h0000);
    add(0,0,4'b0100,1,1, 1, 2'b11,1,1,2,2,4'b0000,16'h0100);
    add(0,0,4'b0000,0,0,19, 2'b11,1,1,2,1,4'b0000,16'h0100);
    add(0,0,4'b0000,0,0, 1, 2'b01,0,0,2,0,4'b0000,16'h0100);
    add(1,0,4'b0000,0,0, 1, 2'b01,0,0,0,0,4'b0000,16'h0000);
    add(0,1,4'b0000,0,0, 1, 2'b01,1,0,0,5,4'b0000,16'h0000);
    add(0,0,4'b1010,0,0, 1, 2'b01,1,1,1,5,4'b0000,16'h0000);
    add(0,0,4'b1010,1,1, 1, 2'b11,1,1,1,2,4'b0000,16'h0010);
    add(0,0,4'b0000,0,0,20, 2'b01,0,0,1,0,4'b0000,16'h0010);
    add(0,1,4'b0000,0,0, 1, 2'b01,1,0,1,5,4'b0000,16'h0010);
    add(0,0,4'b1010,0,0, 1, 2'b01,1,1,3,5,4'b0000,16'h0010);
    add(0,0,4'b1010,1,0, 1, 2'b10,1,1,3,2,4'b1000,16'h0010);
    add(0,0,4'b0000,0,0,20, 2'b01,1,0,3,5,4'b1000,16'h0010);
    add(0,0,4'b0100,0,0, 1, 2'b01,1,1,2,5,4'b1000,16'h0010);
    add(0,0,4'b0100,1,0, 1, 2'b10,1,1,2,2,4'b1100,16'h0010);
    add(0,0,4'b0000,0,0,20, 2'b01,1,0,2,5,4'b1100,16'h0010);
    add(0,0,4'b0100,0,0, 1, 2'b01,1,0,2,5,4'b1100,16'h0010);
    add(0,0,4'b0101,0,0, 1, 2'b01,1,1,0,5,4'b1100,16'h0010);
    add(0,0,4'b0000,0,0,49, 2'b01,1,1,0,1,4'b1100,16'h0010);
    add(0,0,4'b0000,0,0, 1, 2'b10,1,1,0,2,4'b1101,16'h0010);
    add(0,0,4'b0000,0,0,20, 2'b01,1,0,0,5,4'b1101,16'h0010);
    add(0,0,4'b0010,0,0, 1, 2'b01,1,1,1,5,4'b1101,16'h0010);
    add(0,0,4'b0010,1,0, 1, 2'b10,1,1,1,2,4'b1111,16'h0010);
    add(0,0,4'b0000,0,0,20, 2'b01,0,0,1,0,4'b1111,16'h0010);
    add(0,1,4'b0000,0,0, 1, 2'b01,1,0,1,5,4'b0000,16'h0010);
    add(0,0,4'b0001,0,0, 1, 2'b01,1,1,0,5,4'b0000,16'h0010);
    add(0,0,4'b0000,0,0,49, 2'b01,1,1,0,1,4'b0000,16'h0010);
    add(0,0,4'b0000,1,1, 1, 2'b11,1,1,0,2,4'b0000,16'h0011);
    add(0,0,4'b0000,0,0,20, 2'b01,0,0,0,0,4'b0000,16'h0011);
    add(0,1,4'b0000,0,0, 1, 2'b01,1,0,0,5,4'b0000,16'h0011);
    add(0,0,4'b0000,0,0,49, 2'b01,1,0,0,1,4'b0000,16'h0011);
    add(0,0,4'b0000,0,0, 1, 2'b01,0,0,0,0,4'b0000,16'h0011);
    add(0,1,4'b0000,0,0, 1, 2'b01,1,0,0,5,4'b0000,16'h0011);
    add(0,0,4'b0010,0,0, 1, 2'b01,1,1,1,5,4'b0000,16'h0011);
    add(1,0,4'b0010,0,0, 1, 2'b01,0,0,0,0,4'b0000,16'h0000);
    add(1,1,4'b0000,0,0, 1, 2'b01,0,0,0,0,4'b0000,16'h0000);
    add(0,0,4'b0000,0,0, 1, 2'b01,0,0,0,0,4'b0000,16'h0000);

    step(2);
    check("reset", {2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 16'h0000});
    globalReset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      globalReset  = vecs[i].rst;
      startRound   = vecs[i].start;
      buzz         = vecs[i].bz;
      judgeValid   = vecs[i].jv;
      judgeCorrect = vecs[i].jc;
      step(1);
      globalReset = 1'b0; startRound = 1'b0; judgeValid = 1'b0; judgeCorrect = 1'b0;
      if (vecs[i].cycles > 1) step(vecs[i].cycles - 1);
      check($sformatf("vec%0d", i), {vecs[i].scr, vecs[i].act, vecs[i].wv, vecs[i].wid,
                                      vecs[i].sl, vecs[i].lock, vecs[i].sc});
    end

    // Player 0 wins sixteen rounds; the score must saturate at 15.
    for (int k = 1; k <= 16; k++) begin
      int exp_sc;
      exp_sc = (k > 15) ? 15 : k;
      startRound = 1'b1; step(1); startRound = 1'b0;
      buzz = 4'b0001; step(1);
      judgeValid = 1'b1; judgeCorrect = 1'b1; step(1);
      judgeValid = 1'b0; judgeCorrect = 1'b0; buzz = 4'b0000;
      step(20);
      check($sformatf("sat%0d", k), {2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 12'h000, 4'(exp_sc)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
